// File: rtl/dnn_pkg.sv
// dnn_pkg: shared types and constants for the DNN weight fetch path
package dnn_pkg;
    localparam int LINE_BYTES = 64;
    typedef logic [7:0][63:0] line_t;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, DRAIN} fetch_state_t;
endpackage

// File: rtl/dnn_line_buf.sv
// dnn_line_buf: single-entry line buffer with valid flag
module dnn_line_buf
    import dnn_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_load,
    input  logic  i_take,
    input  line_t i_data,
    output line_t o_data,
    output logic  o_valid
);
    line_t r_data;
    logic  r_valid;
    // capture a line on load; take empties the entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (i_load) r_data <= i_data;
            r_valid <= i_load | (r_valid & ~i_take);
        end
    end
    assign o_data  = r_data;
    assign o_valid = r_valid;
endmodule

// File: rtl/dnn_weight_fetch.sv
// dnn_weight_fetch: prefetching line responder between host memory and the DNN weight loader
module dnn_weight_fetch
    import dnn_pkg::*;
#(
    parameter int LINE_WORDS = 8,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [63:0]                  base_addr,
    input  logic [CNT_W-1:0]             num_lines,
    input  logic                         req_mem,
    output logic                         mem_ready,
    output logic [LINE_WORDS*8-1:0][7:0] mem_data,
    output logic                         rd_req,
    output logic [63:0]                  rd_addr,
    input  logic                         rd_ready,
    input  logic                         rd_valid,
    input  logic [LINE_WORDS*8-1:0][7:0] rd_data,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun
);
    fetch_state_t     r_state, w_next;
    logic [63:0]      r_base;
    logic [CNT_W-1:0] r_num, r_fetch_idx, r_deliver_idx;
    logic [1:0]       r_owed;
    logic             r_mem_ready, r_busy, r_done, r_overrun;
    line_t            r_mem_data, w_buf_data;
    logic             w_buf_valid, w_start_ok, w_fill, w_req_ok, w_want, w_deliver;

    assign w_start_ok = start && r_state == IDLE && !r_busy;
    assign w_fill     = r_state == WAIT && rd_valid;
    assign w_req_ok   = req_mem && r_deliver_idx != r_num;
    // a request arriving this cycle counts as owed, and a line arriving this cycle counts as held
    assign w_want     = r_owed != 2'd0 || w_req_ok;
    assign w_deliver  = w_want && (w_buf_valid || w_fill);

    dnn_line_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_fill && !w_want),
        .i_take  (w_deliver && w_buf_valid),
        .i_data  (rd_data),
        .o_data  (w_buf_data),
        .o_valid (w_buf_valid)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next state and read request
    always_comb begin
        w_next = r_state;
        rd_req = 1'b0;
        case (r_state)
            IDLE:    if (w_start_ok && num_lines != '0) w_next = FETCH;
            FETCH: begin
                rd_req = 1'b1;
                if (rd_ready) w_next = WAIT;
            end
            WAIT:    if (rd_valid) w_next = HOLD;
            HOLD:    if (!w_buf_valid) w_next = r_fetch_idx < r_num ? FETCH :
                                                r_deliver_idx == r_num ? IDLE : DRAIN;
            DRAIN:   if (r_deliver_idx == r_num) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign rd_addr = rd_req ? r_base + 64'(r_fetch_idx) * 64'(LINE_BYTES) : 64'd0;

    // load parameters, line counters, owed count and overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base        <= '0;
            r_num         <= '0;
            r_fetch_idx   <= '0;
            r_deliver_idx <= '0;
            r_owed        <= '0;
            r_overrun     <= 1'b0;
        end else if (w_start_ok) begin
            r_base        <= base_addr;
            r_num         <= num_lines;
            r_fetch_idx   <= '0;
            r_deliver_idx <= '0;
            r_owed        <= 2'd1;
            r_overrun     <= 1'b0;
        end else begin
            if (rd_req && rd_ready) r_fetch_idx <= r_fetch_idx + CNT_W'(1);
            if (w_deliver) r_deliver_idx <= r_deliver_idx + CNT_W'(1);
            if ((req_mem && !w_req_ok) || (w_req_ok && !w_deliver && r_owed == 2'd2)) r_overrun <= 1'b1;
            if (w_req_ok && !w_deliver && r_owed != 2'd2) r_owed <= r_owed + 2'd1;
            else if (w_deliver && !w_req_ok) r_owed <= r_owed - 2'd1;
        end
    end

    // delivery pulse, held line data, done pulse and busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_ready <= 1'b0;
            r_mem_data  <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_mem_ready <= w_deliver;
            if (w_deliver) r_mem_data <= w_buf_valid ? w_buf_data : rd_data;
            r_done <= w_start_ok ? num_lines == '0 : w_deliver && r_deliver_idx + CNT_W'(1) == r_num;
            r_busy <= r_done ? 1'b0 : r_busy | w_start_ok;
        end
    end

    assign mem_ready = r_mem_ready;
    assign mem_data  = r_mem_data;
    assign done      = r_done;
    assign busy      = r_busy;
    assign overrun   = r_overrun;
endmodule
